// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared 8-bit ALU: accepts one request at a time,
// drives the ALU for a single cycle and holds the result until the winner takes it.
module alu_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic [3*NUM_REQ-1:0] req_op_i,
   input  logic [8*NUM_REQ-1:0] req_a_i,
   input  logic [8*NUM_REQ-1:0] req_b_i,
   output logic [NUM_REQ-1:0]   resp_valid_o,
   input  logic [NUM_REQ-1:0]   resp_ready_i,
   output logic [7:0]           resp_data_o,
   output logic                 busy_o,
   output logic [7:0]           alu_a_o,
   output logic [7:0]           alu_b_o,
   output logic [2:0]           alu_op_o,
   output logic                 alu_en_o,
   input  logic [7:0]           alu_result_i
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e               state_q;
   logic [IW-1:0]        ptr_q;
   logic [IW-1:0]        grant_q;
   logic [NUM_REQ-1:0]   resp_valid_q;
   logic [7:0]           resp_data_q;
   logic [7:0]           alu_a_q;
   logic [7:0]           alu_b_q;
   logic [2:0]           alu_op_q;
   logic                 alu_en_q;

   logic [IW-1:0]        win_d;
   logic                 win_vld_d;
   logic [IW-1:0]        cand;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Search starts just after the last winner so every requester gets its turn.
   always_comb begin
      win_d     = '0;
      win_vld_d = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IW'((int'(ptr_q) + i) % NUM_REQ);
         if (!win_vld_d && req_valid_i[cand]) begin
            win_d     = cand;
            win_vld_d = 1'b1;
         end
      end
   end

   // Gated by reset so the grant drops the instant reset is applied.
   assign req_ready_o  = (rst_n_i && state_q == IDLE && win_vld_d) ? onehot(win_d) : '0;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign busy_o       = (state_q != IDLE);
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_op_o     = alu_op_q;
   assign alu_en_o     = alu_en_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         ptr_q        <= IW'(NUM_REQ - 1);
         grant_q      <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         alu_en_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_vld_d) begin
                  alu_a_q  <= req_a_i[8*int'(win_d) +: 8];
                  alu_b_q  <= req_b_i[8*int'(win_d) +: 8];
                  alu_op_q <= req_op_i[3*int'(win_d) +: 3];
                  alu_en_q <= 1'b1;
                  ptr_q    <= win_d;
                  grant_q  <= win_d;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               alu_en_q     <= 1'b0;
               resp_data_q  <= alu_result_i;
               resp_valid_q <= onehot(grant_q);
               state_q      <= RESP;
            end
            RESP: begin
               if (resp_ready_i[grant_q]) begin
                  resp_valid_q <= '0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               alu_en_q     <= 1'b0;
               resp_valid_q <= '0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

endmodule
